seq_divider_10by5: RTL

- Sequential restoring divider, the inverse of the 5x5-bit multiplier datapath.
- Takes a dividend up to product width (10 bits) and a 5-bit divisor.
- Produces quotient and remainder one bit per clock.
- Used wherever a multiplier product must be reduced back to its factors, or checked against them.

---
 rtl/seq_divider_10by5_if.sv | 26 ++
 rtl/seq_divider_10by5.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seq_divider_10by5_if.sv
// Request/result bundle for the sequential 10-by-5 restoring divider.
interface seq_divider_10by5_if #(
  parameter int unsigned DW = 10,
  parameter int unsigned VW = 5
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider_10by5.sv
// Sequential restoring divider: one quotient bit per clock, DW RUN cycles per
// division, a short ZERO path when the divisor is 0.
module seq_divider_10by5 #(
  parameter int unsigned DW = 10,
  parameter int unsigned VW = 5
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_10by5_if.slave bus
);
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   pr_q, pr_d;
  logic [DW-1:0] qsr_q, qsr_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   pr_shift;
  logic          ge;
  logic [VW:0]   pr_step;
  logic [DW-1:0] q_step;

  // Single restoring step shared by every RUN cycle, including the last one,
  // whose result goes straight to the output registers.
  always_comb begin
    pr_shift = {pr_q[VW-1:0], dvd_q[DW-1]};
    ge       = (pr_shift >= {1'b0, dvs_q});
    pr_step  = ge ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
    q_step   = {qsr_q[DW-2:0], ge};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    qsr_d   = qsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          pr_d    = '0;
          qsr_d   = '0;
          count_d = '0;
          state_d = (bus.divisor != '0) ? RUN : ZERO;
        end
      end
      RUN: begin
        pr_d    = pr_step;
        qsr_d   = q_step;
        dvd_d   = dvd_q << 1;
        count_d = count_q + 1'b1;
        if (count_q == CW'(DW - 1)) begin
          quo_d   = q_step;
          rem_d   = pr_step[VW-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      ZERO: begin
        quo_d   = '1;
        rem_d   = dvd_q[VW-1:0];
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      qsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      qsr_q   <= qsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule
